// File: rtl/ita_scroll_src.sv
// Message buffer and scrolling 12-digit window feeding the 14-segment display multiplexer.
// Returns the registered segment pattern for the digit position requested each cycle.
module ita_scroll_src #(
  parameter int DEPTH  = 32,
  parameter int DIV    = 1_000_000,
  parameter int DIGITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_char,
  input  logic        wr_last,
  input  logic        scroll_en,
  input  logic [3:0]  dig_idx,
  output logic [13:0] seg,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  wr_ptr, wr_ptr_nxt;
  logic [LW-1:0]  len, len_nxt;
  logic [PW-1:0]  offset, offset_nxt;
  logic [DW-1:0]  divider, divider_nxt;
  logic [7:0]     mem [DEPTH];
  logic           accept;
  logic           commit;
  logic [PW-1:0]  wr_idx;
  logic [LW-1:0]  pos_sum;
  logic [PW-1:0]  pos;
  logic [13:0]    seg_nxt;

  function automatic logic [13:0] enc(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    case (u)
      8'h41:   enc = 14'b11101111000000;
      8'h43:   enc = 14'b10011100000000;
      8'h44:   enc = 14'b11110000010010;
      8'h45:   enc = 14'b10011110000000;
      8'h49:   enc = 14'b10010000010010;
      8'h4c:   enc = 14'b00011100000000;
      8'h4f:   enc = 14'b11111100000000;
      8'h50:   enc = 14'b11001111000000;
      8'h53:   enc = 14'b10110111000000;
      8'h54:   enc = 14'b10000000010010;
      8'h55:   enc = 14'b01111100000000;
      default: enc = 14'd0;
    endcase
  endfunction

  assign wr_ready = ~rst;
  assign accept   = wr_valid & wr_ready;
  // A write outside LOAD always restarts the message at index 0.
  assign wr_idx   = (state == LOAD) ? wr_ptr : '0;
  assign commit   = accept & (wr_last | (wr_idx == PW'(DEPTH - 1)));
  assign busy     = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      len     <= '0;
      offset  <= '0;
      divider <= '0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      len     <= len_nxt;
      offset  <= offset_nxt;
      divider <= divider_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    len_nxt     = len;
    offset_nxt  = offset;
    divider_nxt = divider;
    if (accept) begin
      wr_ptr_nxt  = wr_idx + PW'(1);
      offset_nxt  = '0;
      divider_nxt = '0;
      if (commit) begin
        len_nxt   = LW'(wr_idx) + LW'(1);
        state_nxt = SHOW;
      end else begin
        state_nxt = LOAD;
      end
    end else if (state == SHOW && scroll_en && len > LW'(DIGITS)) begin
      if (divider == DW'(DIV - 1)) begin
        divider_nxt = '0;
        offset_nxt  = (LW'(offset) == len - LW'(1)) ? '0 : offset + PW'(1);
      end else begin
        divider_nxt = divider + DW'(1);
      end
    end else begin
      divider_nxt = divider;
    end
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx] <= wr_char;
    end
  end

  // offset+k stays below 2*len, so a single conditional subtraction wraps it.
  always_comb begin
    pos_sum = LW'(offset) + LW'(dig_idx);
    pos     = PW'((pos_sum >= len) ? pos_sum - len : pos_sum);
    if (state == SHOW && dig_idx < 4'(DIGITS) &&
        (len > LW'(DIGITS) || LW'(dig_idx) < len)) begin
      seg_nxt = enc(mem[pos]);
    end else begin
      seg_nxt = 14'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 14'd0;
    end else begin
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_ita_scroll_src.sv
// Directed plus randomized bench for ita_scroll_src against a message-level reference model.
module tb_ita_scroll_src;

  localparam int DEPTH  = 32;
  localparam int DIV    = 4;
  localparam int DIGITS = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_char;
  logic        wr_last;
  logic        scroll_en;
  logic [3:0]  dig_idx;
  logic [13:0] seg;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: the message as a byte array plus window position.
  byte unsigned msg [DEPTH];
  int  m_len = 0, m_off = 0, m_div = 0, m_cnt = 0;
  bit  loading = 1'b0, showing = 1'b0;

  string       letters = "ACDEILOPSTU";
  logic [13:0] pats [11] = '{14'b11101111000000, 14'b10011100000000, 14'b11110000010010,
                             14'b10011110000000, 14'b10010000010010, 14'b00011100000000,
                             14'b11111100000000, 14'b11001111000000, 14'b10110111000000,
                             14'b10000000010010, 14'b01111100000000};
  string       charset = "ACDEILOPSTUacdeilopstu #9xZ";

  localparam logic [13:0] SEG_A = 14'b11101111000000;
  localparam logic [13:0] SEG_C = 14'b10011100000000;

  ita_scroll_src #(.DEPTH(DEPTH), .DIV(DIV), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_char(wr_char), .wr_last(wr_last), .scroll_en(scroll_en),
    .dig_idx(dig_idx), .seg(seg), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] model_enc(input byte unsigned c);
    byte unsigned u;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'd32 : c;
    for (int i = 0; i < letters.len(); i++)
      if (letters[i] == u) return pats[i];
    return 14'd0;
  endfunction

  function automatic logic [13:0] model_seg(input int k);
    if (!showing || k >= DIGITS || (m_len <= DIGITS && k >= m_len)) return 14'd0;
    return model_enc(msg[(m_off + k) % m_len]);
  endfunction

  task automatic model_step(input bit r, input bit v, input byte unsigned ch, input bit last,
                            input bit sc);
    if (r) begin
      loading = 1'b0; showing = 1'b0;
      m_cnt = 0; m_len = 0; m_off = 0; m_div = 0;
    end else if (v) begin
      if (!loading) m_cnt = 0;
      msg[m_cnt] = ch;
      m_cnt++;
      m_off = 0; m_div = 0;
      if (last || m_cnt == DEPTH) begin
        m_len = m_cnt; showing = 1'b1; loading = 1'b0;
      end else begin
        loading = 1'b1; showing = 1'b0;
      end
    end else if (showing && sc && m_len > DIGITS) begin
      m_div++;
      if (m_div == DIV) begin
        m_div = 0;
        m_off = (m_off + 1) % m_len;
      end
    end
  endtask

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit r, input bit v, input byte unsigned ch, input bit last,
                      input bit sc, input int idx);
    logic [13:0] exp_seg;
    rst = r; wr_valid = v; wr_char = ch; wr_last = last; scroll_en = sc; dig_idx = idx[3:0];
    exp_seg = r ? 14'd0 : model_seg(idx);
    @(posedge clk);
    model_step(r, v, ch, last, sc);
    #1;
    check("seg", seg, exp_seg);
    check("busy", {13'd0, busy}, {13'd0, loading});
    check("wr_ready", {13'd0, wr_ready}, {13'd0, ~r});
  endtask

  task automatic idle(input int n, input bit sc);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, sc, $urandom_range(0, 15));
  endtask

  task automatic write_str(input string s, input bit last, input bit sc);
    for (int i = 0; i < s.len(); i++)
      tick(1'b0, 1'b1, s[i], last && (i == s.len() - 1), sc, $urandom_range(0, 15));
  endtask

  logic [13:0] cap_lit [12];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cap_lit = '{14'b10011100000000, 14'b11101111000000, 14'b11001111000000,
                14'b10010000010010, 14'b10000000010010, 14'b01111100000000,
                14'b00011100000000, 14'b11111100000000, 14'd0,
                14'b10011110000000, 14'b11110000010010, 14'b10110111000000};

    // Reset and hold, sweeping the digit index.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, i);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, i);

    // Short message fits the window; it must never scroll.
    write_str("CAPITULO EDS", 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, k);
      check("cap_lit", seg, cap_lit[k]);
    end
    for (int k = 0; k < 3 * DIV; k++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, k % 12);
      check("cap_hold", seg, cap_lit[k % 12]);
    end

    // 14-char message scrolls every DIV cycles; after 13 steps digit 1 wraps to 'A'.
    write_str("ACDEILOPSTU ca", 1'b1, 1'b1);
    for (int i = 0; i < 13 * DIV; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1);
    check("wrap13_dig1", seg, SEG_A);
    for (int i = 0; i < DIV - 1; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1);
    check("wrap14_dig1", seg, SEG_C);

    // Freeze with scroll_en low, then resume.
    idle(2 * DIV + 1, 1'b0);
    idle(3 * DIV, 1'b1);

    // Interrupting write lands on a divider wrap edge.
    for (int n = 0; n < 20 && m_div != DIV - 1; n++) idle(1, 1'b1);
    check("wrap_align", 14'(m_div), 14'(DIV - 1));
    tick(1'b0, 1'b1, "a", 1'b0, 1'b1, 0);
    check("irq_busy", {13'd0, busy}, 14'd1);
    idle(3, 1'b1);
    write_str("#9", 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, k);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    check("a_dig0", seg, SEG_A);

    // Full buffer: 32 writes without wr_last commit implicitly.
    for (int i = 0; i < DEPTH; i++)
      tick(1'b0, 1'b1, charset[$urandom_range(0, charset.len() - 1)], 1'b0, 1'b1,
           $urandom_range(0, 15));
    check("full_busy", {13'd0, busy}, 14'd0);
    idle(DEPTH * DIV + 10, 1'b1);

    // Randomized messages, gaps and scroll gating.
    for (int m = 0; m < 8; m++) begin
      int n;
      n = (m == 0) ? 1 : $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'($urandom));
        tick(1'b0, 1'b1, charset[$urandom_range(0, charset.len() - 1)], i == n - 1,
             1'($urandom), $urandom_range(0, 15));
      end
      idle($urandom_range(20, 60), 1'($urandom_range(0, 3) != 0));
    end

    // Reset mid-LOAD and mid-SHOW.
    write_str("PL", 1'b0, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    check("rst_load_busy", {13'd0, busy}, 14'd0);
    for (int k = 0; k < 12; k++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, k);
    write_str("TO", 1'b1, 1'b1);
    idle(3, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
